serial_grade_averager: RTL and testbench
========================================

Name: serial_grade_averager

Overview:
Sequential counterpart of the combinational three-grade average comparator. It accepts grades one per transfer over a valid/ready interface and accumulates N_GRADES of them. It then computes the integer average and remainder with a shift-subtract divider, and presents average, remainder and pass flag on a second valid/ready interface. It sits between a grade source (switches/UART/keypad front-end) and display/comparison logic.

Parameters:
DATA_W, 4, width of one grade (unsigned)
N_GRADES, 3, grades per average; legal range 2..4
THRESHOLD, 6, pass threshold; pass when true average >= THRESHOLD
(localparam SUM_W = DATA_W + 2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort; discards partial accumulation
in_grade  in  DATA_W  grade value
in_valid  in  1  in_grade valid
in_ready  out  1  block can accept a grade
out_avg  out  DATA_W  quotient sum/N_GRADES (rounded if AVG_ROUND_EN)
out_rem  out  2  remainder sum mod N_GRADES
out_pass  out  1  1 when sum >= THRESHOLD*N_GRADES
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
count  out  2  grades accepted in current set

Behaviour:
- Reset (async, rst=1): state COLLECT; sum=0; count=0; out_avg=0, out_rem=0, out_pass=0, out_valid=0; in_ready=1 the cycle after rst deasserts (combinational from state).
- States: COLLECT, DIVIDE, HOLD.
- COLLECT: in_ready=1. Grade accepted on an edge with in_valid&in_ready: sum += in_grade (zero-extended to SUM_W), count++. When the accepted grade is the N_GRADES-th: go to DIVIDE, load the divider with the final sum, count returns to 0.
- DIVIDE: in_ready=0. Restoring shift-subtract, one quotient bit per cycle, exactly SUM_W cycles. The dividend is the full sum; the divisor is N_GRADES. Then go to HOLD.
- HOLD: out_valid=1, outputs stable. On an edge with out_ready=1: out_valid drops, sum clears, state returns to COLLECT.
- Latency: out_valid is high from edge (SUM_W+1) after the edge accepting the last grade. No out_ready-to-in_ready bypass: one idle cycle minimum between sets.
- out_pass is computed from the exact sum by comparison, independent of the quotient and rounding.
- Widths: maximum sum 4*15=60 fits 6 bits. The quotient fits DATA_W (max 15). No overflow is possible within the legal parameter range.
- The outputs out_avg, out_rem and out_pass hold their last result outside HOLD. They update only on the DIVIDE->HOLD transition.
- clear=1 (synchronous, overrides all but rst): state COLLECT, sum=0, count=0, out_valid=0. Last-result outputs are retained. A grade presented in the same cycle as clear is dropped.
- in_valid while in_ready=0: ignored; the source must hold it (standard valid/ready).
- rst asserted mid-DIVIDE or mid-HOLD: immediate return to reset values. A pending result is lost.
- out_ready while out_valid=0: no effect.

Optional Feature:
AVG_ROUND_EN. When defined, out_avg = quotient + 1 if 2*remainder >= N_GRADES (round half up), saturating at 2^DATA_W-1; out_rem still reports the raw remainder. When undefined, out_avg is the truncated quotient. out_pass and latency are unchanged in both builds.

Test Plan:
- Grades 7,8,6 back-to-back with out_ready=1 -> out_valid 7 edges after 3rd accept; avg=7, rem=0, pass=1.
- Grades 4,5,5 -> sum 14: avg=4 (5 with AVG_ROUND_EN), rem=2, pass=0. Grades 5,7,3 -> avg=5, rem=0, pass=0.
- Grades 6,6,6 -> avg=6, pass=1. Grades 15,15,15 -> avg=15, rem=0, pass=1; rounding build gives no saturation error.
- Backpressure: out_ready=0 for 20 cycles with 10,10,10 -> out_valid held, outputs stable at avg=10, in_ready=0 throughout; out_ready=1 -> out_valid drops next edge, in_ready=1.
- Grades 9,9, then clear=1 with in_valid=1, then 1,1,1 -> clear drops the grade, count=0; result avg=1, pass=0. Sum contains no trace of the 9s.
- rst pulsed during DIVIDE of 7,8,6 -> all outputs 0, out_valid never rises; next set 6,6,6 averages correctly.

Source files
------------

// File: rtl/serial_grade_averager.sv
// Serial grade averager: collects N_GRADES grades over valid/ready, divides the
// sum with a restoring shift-subtract divider. Optional rounding: AVG_ROUND_EN.
module serial_grade_averager #(
  parameter int DATA_W    = 4,
  parameter int N_GRADES  = 3,
  parameter int THRESHOLD = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_grade,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic [1:0]        out_rem,
  output logic              out_pass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        count
);

  localparam int SUM_W = DATA_W + 2;
  localparam int BIT_W = $clog2(SUM_W + 1);
  localparam logic [SUM_W-1:0] DIVISOR  = SUM_W'(N_GRADES);
  localparam logic [1:0]       LAST_CNT = 2'(N_GRADES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SUM_W);
  localparam logic [31:0]      PASS_SUM = 32'(THRESHOLD * N_GRADES);

  typedef enum logic [1:0] {COLLECT, DIVIDE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [1:0]          count_q, count_d;
  logic [SUM_W-1:0]    rem_q, rem_d;
  logic [SUM_W-1:0]    quo_q, quo_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   avg_q, avg_d;
  logic [1:0]          orem_q, orem_d;
  logic                pass_q, pass_d;
  logic [SUM_W-1:0]    sum_acc;
  logic [2*SUM_W-1:0]  step;

  // One restoring step: shift in the next dividend bit, keep the trial
  // difference only when it is non-negative. The quotient fills quo from the LSB.
  function automatic logic [2*SUM_W-1:0] div_step(input logic [SUM_W-1:0] rem,
                                                  input logic [SUM_W-1:0] quo);
    logic [SUM_W:0]          shifted;
    logic signed [SUM_W+1:0] trial;
    shifted = {rem, quo[SUM_W-1]};
    trial   = $signed({1'b0, shifted}) - $signed({2'b00, DIVISOR});
    if (!trial[SUM_W+1])
      return {trial[SUM_W-1:0], quo[SUM_W-2:0], 1'b1};
    else
      return {shifted[SUM_W-1:0], quo[SUM_W-2:0], 1'b0};
  endfunction

`ifdef AVG_ROUND_EN
  // Round half up, saturating at the largest grade value.
  function automatic logic [DATA_W-1:0] round_avg(input logic [SUM_W-1:0] quo,
                                                  input logic [SUM_W-1:0] rem);
    logic           up;
    logic [SUM_W:0] q1;
    up = ({1'b0, rem} << 1) >= (SUM_W+1)'(N_GRADES);
    q1 = {1'b0, quo} + {{SUM_W{1'b0}}, up};
    if (q1 > (SUM_W+1)'((1 << DATA_W) - 1))
      return '1;
    else
      return q1[DATA_W-1:0];
  endfunction
`endif

  assign sum_acc = sum_q + SUM_W'(in_grade);
  assign step    = div_step(rem_q, quo_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    avg_d   = avg_q;
    orem_d  = orem_q;
    pass_d  = pass_q;
    if (clear) begin
      state_d = COLLECT;
      sum_d   = '0;
      count_d = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (in_valid) begin
            sum_d = sum_acc;
            if (count_q == LAST_CNT) begin
              state_d = DIVIDE;
              count_d = '0;
              rem_d   = '0;
              quo_d   = sum_acc;
              bit_d   = '0;
            end else begin
              count_d = count_q + 2'd1;
            end
          end
        end
        DIVIDE: begin
          if (bit_q == LAST_BIT) begin
            state_d = HOLD;
`ifdef AVG_ROUND_EN
            avg_d   = round_avg(quo_q, rem_q);
`else
            avg_d   = quo_q[DATA_W-1:0];
`endif
            orem_d  = rem_q[1:0];
            pass_d  = ({{(32-SUM_W){1'b0}}, sum_q} >= PASS_SUM);
          end else begin
            {rem_d, quo_d} = step;
            bit_d          = bit_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = COLLECT;
            sum_d   = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      avg_q   <= '0;
      orem_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      avg_q   <= avg_d;
      orem_q  <= orem_d;
      pass_q  <= pass_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_avg   = avg_q;
  assign out_rem   = orem_q;
  assign out_pass  = pass_q;
  assign count     = count_q;

endmodule

// File: tb/tb_serial_grade_averager.sv
// Bench for serial_grade_averager: cycle-level reference model plus directed
// and randomized grade sets.
module tb_serial_grade_averager;

  localparam int N  = 3;
  localparam int T  = 6;
  localparam int SW = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] in_grade = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out_avg;
  logic [1:0] out_rem;
  logic       out_pass;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] count;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rnd_done = 1'b0;

  // Reference model state
  int m_cnt = 0, m_sum = 0, m_busy = 0;
  bit m_valid = 1'b0;
  int e_avg = 0, e_rem = 0;
  bit e_pass = 1'b0;

  serial_grade_averager #(.DATA_W(4), .N_GRADES(N), .THRESHOLD(T)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_grade(in_grade),
    .in_valid(in_valid), .in_ready(in_ready), .out_avg(out_avg),
    .out_rem(out_rem), .out_pass(out_pass), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  function automatic int ref_avg(input int s);
    int a;
`ifdef AVG_ROUND_EN
    a = (2 * s + N) / (2 * N);
    if (a > 15) a = 15;
`else
    a = s / N;
`endif
    return a;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_sum <= 0; m_busy <= 0; m_valid <= 1'b0;
      e_avg <= 0; e_rem <= 0; e_pass <= 1'b0;
    end else if (clear) begin
      m_cnt <= 0; m_sum <= 0; m_busy <= 0; m_valid <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_sum   <= 0;
      end
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_valid <= 1'b1;
        e_avg   <= ref_avg(m_sum);
        e_rem   <= m_sum % N;
        e_pass  <= (m_sum >= T * N);
      end
    end else if (in_valid) begin
      m_sum <= m_sum + int'(in_grade);
      if (m_cnt == N - 1) begin
        m_cnt  <= 0;
        m_busy <= SW + 1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] g);
    bit done = 1'b0;
    bit rdy;
    in_grade = g;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check_lit("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_set(input logic [3:0] g0, input logic [3:0] g1, input logic [3:0] g2,
                         input int xa, input int xr, input int xp, input string name);
    int lat;
    out_ready = 1'b1;
    send(g0); send(g1); send(g2);
    wait_valid(lat);
    check_lit({name, "_latency"}, lat, SW + 1);
    check_lit({name, "_avg"}, int'(out_avg), xa);
    check_lit({name, "_rem"}, int'(out_rem), xr);
    check_lit({name, "_pass"}, int'(out_pass), xp);
    tick();
    check_lit({name, "_valid_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_lit("reset_in_ready", int'(in_ready), 1);
    check_lit("reset_out_valid", int'(out_valid), 0);
    check_lit("reset_avg", int'(out_avg), 0);
    check_lit("reset_count", int'(count), 0);

    fork
      begin
        run_set(7, 8, 6, 7, 0, 1, "g786");
`ifdef AVG_ROUND_EN
        run_set(4, 5, 5, 5, 2, 0, "g455");
`else
        run_set(4, 5, 5, 4, 2, 0, "g455");
`endif
        run_set(5, 7, 3, 5, 0, 0, "g573");
        run_set(6, 6, 6, 6, 0, 1, "g666");
        run_set(15, 15, 15, 15, 0, 1, "g15x3");

        // Backpressure: result must be held while the consumer stalls
        out_ready = 1'b0;
        send(10); send(10); send(10);
        wait_valid(lat);
        check_lit("bp_latency", lat, SW + 1);
        for (int i = 0; i < 20; i++) begin
          check_lit("bp_valid", int'(out_valid), 1);
          check_lit("bp_avg", int'(out_avg), 10);
          check_lit("bp_in_ready", int'(in_ready), 0);
          tick();
        end
        out_ready = 1'b1;
        tick();
        check_lit("bp_release_valid", int'(out_valid), 0);
        check_lit("bp_release_in_ready", int'(in_ready), 1);

        // Clear drops the partial set and the grade offered with it
        send(9); send(9);
        in_grade = 9; in_valid = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check_lit("clear_count", int'(count), 0);
        run_set(1, 1, 1, 1, 0, 0, "after_clear");

        // Reset in the middle of a division
        send(7); send(8); send(6);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_lit("rst_mid_avg", int'(out_avg), 0);
        check_lit("rst_mid_pass", int'(out_pass), 0);
        check_lit("rst_mid_valid", int'(out_valid), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
          tick();
          check_lit("rst_no_valid", int'(out_valid), 0);
        end
        run_set(6, 6, 6, 6, 0, 1, "after_rst");

        // Randomized sets with idle gaps, random consumer stalls and aborts
        fork
          begin
            for (int s = 0; s < 40; s++) begin
              for (int k = 0; k < N; k++) begin
                logic [3:0] g;
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 24) == 0) begin
                  clear = 1'b1;
                  tick();
                  clear = 1'b0;
                end
                g = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0)
                                               : 4'($urandom_range(0, 15));
                send(g);
              end
            end
            rnd_done = 1'b1;
          end
          begin
            while (!rnd_done) begin
              out_ready = ($urandom_range(0, 2) != 0);
              tick();
            end
          end
        join
        out_ready = 1'b1;
        repeat (20) tick();
      end
      begin
        forever begin
          logic [10:0] act, exp;
          @(negedge clk);
          cyc++;
          act = {in_ready, out_valid, count, out_avg, out_rem, out_pass};
          exp = {(m_busy == 0 && !m_valid), m_valid, 2'(m_cnt), 4'(e_avg), 2'(e_rem), e_pass};
          n_vec++;
          if (act !== exp) begin
            n_bad++;
            $display("FAIL model cyc%0d: dut rdy=%b vld=%b cnt=%0d avg=%0d rem=%0d pass=%b, expected rdy=%b vld=%b cnt=%0d avg=%0d rem=%0d pass=%b",
                     cyc, act[10], act[9], act[8:7], act[6:3], act[2:1], act[0],
                     exp[10], exp[9], exp[8:7], exp[6:3], exp[2:1], exp[0]);
          end
        end
      end
    join_any

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
